// File: rtl/exe_seq_ctrl_pkg.sv
// Shared types for the half-word-serial execute sequencer.
package exe_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_REQ  = 3'd1,
        S_LD_WAIT = 3'd2,
        S_LO      = 3'd3,
        S_HI      = 3'd4
    } exe_seq_state_e;

    typedef struct packed {
        logic load;
        logic store;
        logic branch;
    } exe_cls_s;

    // Load wins when decode flags both load and store.
    function automatic exe_cls_s cls_decode(input logic ld, input logic st, input logic br);
        exe_cls_s c;
        c.load   = ld;
        c.store  = st & ~ld;
        c.branch = br;
        return c;
    endfunction

endpackage

// File: rtl/exe_seq_perf_cnt.sv
// Retired-instruction and stall-cycle counters for exe_seq_ctrl; wrap modulo 2^PERF_W.
module exe_seq_perf_cnt #(
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              retire_i,
    input  logic              stall_i,
    output logic [PERF_W-1:0] retired_o,
    output logic [PERF_W-1:0] stall_o
);

    logic [PERF_W-1:0] retired_q, retired_d;
    logic [PERF_W-1:0] stall_q, stall_d;

    always_comb begin
        retired_d = retire_i ? retired_q + PERF_W'(1) : retired_q;
        stall_d   = stall_i  ? stall_q + PERF_W'(1)   : stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign retired_o = retired_q;
    assign stall_o   = stall_q;

endmodule

// File: rtl/exe_seq_ctrl.sv
// Sequencer for the half-word-serial execute/memory/writeback stage.
// Optional performance counters are built when EXE_SEQ_PERF_EN is defined.
module exe_seq_ctrl
    import exe_seq_ctrl_pkg::*;
#(
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic              is_branch_i,
    output logic              ready_o,
    input  logic              lsu_ready_i,
    input  logic              lsu_valid_i,
    input  logic              cmp_result_i,
    input  logic              cmp_result_valid_i,
    output logic              stage_valid_o,
    output logic              first_cycle_o,
    output logic              load_bypass_o,
    output logic              retire_o,
    output logic              branch_valid_o,
    output logic              branch_taken_o,
    output logic              seq_err_o
`ifdef EXE_SEQ_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_retired_o,
    output logic [PERF_W-1:0] perf_stall_o
`endif
);

    if (PERF_W == 0) begin : g_bad_perf_w
        $error("exe_seq_ctrl: PERF_W must be nonzero");
    end

    exe_seq_state_e state_q, state_d;
    exe_cls_s       cls_q, cls_d;
    exe_cls_s       in_cls;
    logic           err_q, err_d;
    logic           accept;
    logic           store_stall;

    assign in_cls      = cls_decode(is_load_i, is_store_i, is_branch_i);
    assign ready_o     = (state_q == S_IDLE) || (state_q == S_HI);
    assign accept      = valid_i && ready_o;
    assign store_stall = (state_q == S_LO) && cls_q.store && !lsu_ready_i;

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_HI: begin
                if (accept) begin
                    cls_d   = in_cls;
                    state_d = in_cls.load ? S_LD_REQ : S_LO;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LD_REQ:  if (lsu_ready_i) state_d = S_LD_WAIT;
            S_LD_WAIT: if (lsu_valid_i) state_d = S_LO;
            S_LO:      if (!store_stall) state_d = S_HI;
            default:   state_d = S_IDLE;
        endcase
        if ((state_q == S_HI) && cls_q.branch && !cmp_result_valid_i) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cls_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            err_q   <= err_d;
        end
    end

    assign load_bypass_o  = (state_q == S_LD_REQ) && cls_q.load && lsu_ready_i;
    assign first_cycle_o  = (state_q == S_LO);
    assign stage_valid_o  = ((state_q == S_LO) && !store_stall) || (state_q == S_HI);
    assign retire_o       = (state_q == S_HI);
    assign branch_valid_o = (state_q == S_HI) && cls_q.branch && cmp_result_valid_i;
    assign branch_taken_o = branch_valid_o && cmp_result_i;
    assign seq_err_o      = err_q;

`ifdef EXE_SEQ_PERF_EN
    logic stall_cycle;

    assign stall_cycle = (state_q == S_LD_REQ) || (state_q == S_LD_WAIT) || store_stall;

    exe_seq_perf_cnt #(
        .PERF_W (PERF_W)
    ) u_perf_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .retire_i  (retire_o),
        .stall_i   (stall_cycle),
        .retired_o (perf_retired_o),
        .stall_o   (perf_stall_o)
    );
`endif

endmodule

// File: tb/tb_exe_seq_ctrl.sv
// Table-driven, scoreboarded bench for exe_seq_ctrl; perf counters checked when EXE_SEQ_PERF_EN is defined.
module tb_exe_seq_ctrl;

    localparam int unsigned PERF_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_i, is_load_i, is_store_i, is_branch_i;
    logic lsu_ready_i, lsu_valid_i, cmp_result_i, cmp_result_valid_i;
    logic ready_o, stage_valid_o, first_cycle_o, load_bypass_o;
    logic retire_o, branch_valid_o, branch_taken_o, seq_err_o;
`ifdef EXE_SEQ_PERF_EN
    logic [PERF_W-1:0] perf_retired_o, perf_stall_o;
`endif

    always #5 clk = ~clk;

    exe_seq_ctrl #(
        .PERF_W (PERF_W)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .valid_i            (valid_i),
        .is_load_i          (is_load_i),
        .is_store_i         (is_store_i),
        .is_branch_i        (is_branch_i),
        .ready_o            (ready_o),
        .lsu_ready_i        (lsu_ready_i),
        .lsu_valid_i        (lsu_valid_i),
        .cmp_result_i       (cmp_result_i),
        .cmp_result_valid_i (cmp_result_valid_i),
        .stage_valid_o      (stage_valid_o),
        .first_cycle_o      (first_cycle_o),
        .load_bypass_o      (load_bypass_o),
        .retire_o           (retire_o),
        .branch_valid_o     (branch_valid_o),
        .branch_taken_o     (branch_taken_o),
        .seq_err_o          (seq_err_o)
`ifdef EXE_SEQ_PERF_EN
        ,
        .perf_retired_o     (perf_retired_o),
        .perf_stall_o       (perf_stall_o)
`endif
    );

    // in  = {valid, load, store, branch, lsu_ready, lsu_valid, cmp, cmp_valid}
    // exp = {ready, stage_valid, first, bypass, retire, br_valid, br_taken, err}
    typedef struct packed {
        logic [7:0] in;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    logic [7:0] outs;
    int         checks = 0;
    int         failures = 0;

    assign outs = {ready_o, stage_valid_o, first_cycle_o, load_bypass_o,
                   retire_o, branch_valid_o, branch_taken_o, seq_err_o};

    task automatic add(input logic [7:0] i, input logic [7:0] e);
        vec_t v;
        v.in  = i;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [7:0] i);
        {valid_i, is_load_i, is_store_i, is_branch_i,
         lsu_ready_i, lsu_valid_i, cmp_result_i, cmp_result_valid_i} = i;
    endtask

    task automatic compare(input string name, input int idx);
        logic [7:0] e;
        e = exp_q.pop_front();
        checks++;
        if (outs !== e) begin
            failures++;
            $display("FAIL %s[%0d] outputs got=%b expected=%b", name, idx, outs, e);
        end
    endtask

    task automatic cmp_val(input string name, input logic [PERF_W-1:0] got, input logic [PERF_W-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int exp_retires;

        // A: single ALU op
        add(8'b1000_1000, 8'b1000_0000);
        add(8'b0000_1000, 8'b0110_0000);
        add(8'b0000_1000, 8'b1100_1000);
        add(8'b0000_1000, 8'b1000_0000);
        // B: three back-to-back ALU ops, valid held until the third is taken
        add(8'b1000_1000, 8'b1000_0000);
        add(8'b1000_1000, 8'b0110_0000);
        add(8'b1000_1000, 8'b1100_1000);
        add(8'b1000_1000, 8'b0110_0000);
        add(8'b1000_1000, 8'b1100_1000);
        add(8'b0000_1000, 8'b0110_0000);
        add(8'b0000_1000, 8'b1100_1000);
        add(8'b0000_1000, 8'b1000_0000);
        // C: load, LSU busy 2 cycles, data 3 cycles after the bypass
        add(8'b1100_0000, 8'b1000_0000);
        add(8'b0000_0000, 8'b0000_0000);
        add(8'b0000_0000, 8'b0000_0000);
        add(8'b0000_1000, 8'b0001_0000);
        add(8'b0000_1000, 8'b0000_0000);
        add(8'b0000_1000, 8'b0000_0000);
        add(8'b0000_1100, 8'b0000_0000);
        add(8'b0000_1000, 8'b0110_0000);
        add(8'b0000_1000, 8'b1100_1000);
        add(8'b0000_1000, 8'b1000_0000);
        // D: two stores, second stalls in LO for 4 cycles
        add(8'b1010_1000, 8'b1000_0000);
        add(8'b1010_1000, 8'b0110_0000);
        add(8'b1010_0000, 8'b1100_1000);
        add(8'b0000_0000, 8'b0010_0000);
        add(8'b0000_0000, 8'b0010_0000);
        add(8'b0000_0000, 8'b0010_0000);
        add(8'b0000_0000, 8'b0010_0000);
        add(8'b0000_1000, 8'b0110_0000);
        add(8'b0000_1000, 8'b1100_1000);
        add(8'b0000_1000, 8'b1000_0000);
        // E: branch taken, branch not taken, branch missing compare (sticky error)
        add(8'b1001_1000, 8'b1000_0000);
        add(8'b0000_1000, 8'b0110_0000);
        add(8'b0000_1011, 8'b1100_1110);
        add(8'b0000_1000, 8'b1000_0000);
        add(8'b1001_1000, 8'b1000_0000);
        add(8'b0000_1000, 8'b0110_0000);
        add(8'b0000_1001, 8'b1100_1100);
        add(8'b0000_1000, 8'b1000_0000);
        add(8'b1001_1000, 8'b1000_0000);
        add(8'b0000_1000, 8'b0110_0000);
        add(8'b0000_1010, 8'b1100_1000);
        add(8'b0000_1000, 8'b1000_0001);
        // F: load+store together behaves as a load; LO must not stall on lsu_ready=0
        add(8'b1110_1000, 8'b1000_0001);
        add(8'b0000_1000, 8'b0001_0001);
        add(8'b0000_0100, 8'b0000_0001);
        add(8'b0000_0000, 8'b0110_0001);
        add(8'b0000_0000, 8'b1100_1001);
        add(8'b0000_0000, 8'b1000_0001);

        drive(8'b0000_0000);
        repeat (3) @(negedge clk);
        exp_q.push_back(8'b1000_0000);
        #1 compare("reset", 0);
`ifdef EXE_SEQ_PERF_EN
        cmp_val("perf_retired_reset", perf_retired_o, '0);
        cmp_val("perf_stall_reset", perf_stall_o, '0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].in);
            exp_q.push_back(vecs[i].exp);
            #1 compare("vec", i);
        end

`ifdef EXE_SEQ_PERF_EN
        exp_retires = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].exp[3]) exp_retires++;
        end
        cmp_val("perf_retired", perf_retired_o, PERF_W'(exp_retires));
        cmp_val("perf_stall", perf_stall_o, PERF_W'(12));
`else
        exp_retires = 0;
`endif

        // Reset asserted while a load waits for data
        @(negedge clk);
        drive(8'b1100_1000);
        exp_q.push_back(8'b1000_0001);
        #1 compare("abort_accept", exp_retires);
        @(negedge clk);
        drive(8'b0000_1000);
        exp_q.push_back(8'b0001_0001);
        #1 compare("abort_ldreq", 0);
        @(negedge clk);
        drive(8'b0000_0000);
        exp_q.push_back(8'b0000_0001);
        #1 compare("abort_ldwait", 0);
        #1 rst_n = 1'b0;
        drive(8'b0000_0100);
        exp_q.push_back(8'b1000_0000);
        #1 compare("abort_now", 0);
`ifdef EXE_SEQ_PERF_EN
        cmp_val("abort_perf_stall", perf_stall_o, '0);
`endif
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp_q.push_back(8'b1000_0000);
            #1 compare("abort_hold", i);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'b0000_1100);
        exp_q.push_back(8'b1000_0000);
        #1 compare("post_reset", 0);
        @(negedge clk);
        drive(8'b0000_1000);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            exp_q.push_back(8'b1000_0000);
            #1 compare("post_reset_idle", i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_seq_ctrl.md
# exe_seq_ctrl

Sequencer for the half-word-serial execute/memory/writeback stage. It accepts one instruction at a time from the decode pipeline register and drives the stage through its two half-word cycles (low half, then high half). It generates the stage's `valid`, `first_cycle` and `dmem_load_bypass` controls, and stalls on the load/store unit's handshake. It reports retirement and branch outcome back to fetch.

## Interface
Parameters:
- `PERF_W`, default 32: width of the performance counters (used only with `EXE_SEQ_PERF_EN`).

Ports:
- `clk`  in  1  core clock, single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `valid_i`  in  1  decode holds a valid instruction.
- `is_load_i`  in  1  instruction class is load; sampled on accept.
- `is_store_i`  in  1  instruction class is store; sampled on accept.
- `is_branch_i`  in  1  instruction is a compare/branch; sampled on accept.
- `ready_o`  out  1  sequencer accepts an instruction this cycle.
- `lsu_ready_i`  in  1  LSU idle and able to start a transfer.
- `lsu_valid_i`  in  1  LSU load data valid (1-cycle pulse).
- `cmp_result_i`  in  1  ALU compare result.
- `cmp_result_valid_i`  in  1  ALU compare result valid.
- `stage_valid_o`  out  1  to stage `valid_i`.
- `first_cycle_o`  out  1  to stage `first_cycle`; 1 in the low-half cycle.
- `load_bypass_o`  out  1  to stage `dmem_load_bypass_i`; starts a load transfer.
- `retire_o`  out  1  instruction completes this cycle.
- `branch_valid_o`  out  1  branch outcome valid.
- `branch_taken_o`  out  1  branch outcome.
- `seq_err_o`  out  1  sticky error: a branch reached HI without `cmp_result_valid_i`.
- `perf_retired_o`  out  PERF_W  retired count (`EXE_SEQ_PERF_EN` only).
- `perf_stall_o`  out  PERF_W  stall-cycle count (`EXE_SEQ_PERF_EN` only).

## Operation
- FSM states: IDLE, LD_REQ, LD_WAIT, LO, HI.
- Accept condition: `valid_i && ready_o`. On accept, latch the class bits into `cls_q`. `ready_o` = (state==IDLE) || (state==HI).
- IDLE: on accept, go to LD_REQ if load, otherwise go to LO.
- LD_REQ: `load_bypass_o` = `lsu_ready_i`. Go to LD_WAIT when `lsu_ready_i`=1; otherwise stay.
- LD_WAIT: go to LO on `lsu_valid_i`. The LSU holds the load data until the next transfer starts.
- LO: `first_cycle_o`=1.
  - Store with `lsu_ready_i`=0: `stage_valid_o`=0 and stay in LO (stall, no regfile write, no LSU start).
  - Otherwise: `stage_valid_o`=1, go to HI.
- HI: `first_cycle_o`=0, `stage_valid_o`=1, `retire_o`=1.
  - On accept, go directly to LD_REQ or LO (back-to-back); otherwise go to IDLE.
  - Store transfers continue in the background. Only a following store stalls, in its LO cycle.
- Branch outcome in HI with `cls_q.branch`=1:
  - `branch_valid_o` = `cmp_result_valid_i`; `branch_taken_o` = `cmp_result_i` when valid, else 0.
  - If `cmp_result_valid_i`=0 in that HI cycle, set `seq_err_o`. It stays set until reset.
- Asserting `is_load_i` and `is_store_i` together is illegal input. Load takes priority.

## Timing
- Reset values: state=IDLE, `cls_q`=0, `seq_err_o`=0, counters=0. Every combinational output decodes to 0 in IDLE, except `ready_o`=1.
- `rst_n` low mid-instruction aborts it immediately: no retire and no branch report. An in-flight LSU transfer is reset by the same `rst_n`.
- Latency for non-load, non-stalled instructions: accept at T, LO at T+1, HI and `retire_o` at T+2.
- Back-to-back throughput is one instruction per 2 cycles.
- Load latency: accept at T, LD_REQ at T+1, then LD_WAIT for N cycles until `lsu_valid_i`, then LO, then HI.
- `lsu_valid_i` arriving in the same cycle the FSM enters LD_WAIT is not possible; it is legal on any later cycle.
- All outputs except `seq_err_o` and the counters are combinational from state, `cls_q` and the handshake inputs. There is no input-to-`ready_o` path.

## Configuration
- Macro `EXE_SEQ_PERF_EN`.
- When defined: `perf_retired_o` increments on `retire_o`. `perf_stall_o` increments each cycle in LD_REQ or LD_WAIT, or in LO with `stage_valid_o`=0. Both counters wrap modulo 2^PERF_W.
- When undefined: both ports and both counters are absent.

## Structure
- Shared typedefs package gets:
  - `exe_seq_state_e`: enum of the five states, 3-bit.
  - `exe_cls_s`: packed struct {load, store, branch}.
- One sub-module, `exe_seq_perf_cnt`, holds the two counters. It is instantiated only under `EXE_SEQ_PERF_EN`.

## Test plan
- ALU op accepted from IDLE at cycle 5 → LO at cycle 6 with `first_cycle_o`=1 and `stage_valid_o`=1; HI at cycle 7 with `retire_o`=1; then IDLE.
- Three back-to-back ALU ops with `valid_i` held high → `retire_o` at cycles 2, 4 and 6 after the first accept; `ready_o` high only in IDLE/HI cycles.
- Load with `lsu_ready_i` low for 2 cycles, then `lsu_valid_i` 3 cycles after the bypass → exactly one `load_bypass_o` pulse; LO follows the `lsu_valid_i` cycle; retire follows one cycle later. With perf enabled, stall count = 6.
- Two consecutive stores with `lsu_ready_i` low for 4 cycles after the first start → second store holds LO with `stage_valid_o`=0 for 4 cycles; no retire in that window.
- Branch with `cmp_result_valid_i`=1 and `cmp_result_i`=1 in HI → `branch_valid_o`=1 and `branch_taken_o`=1. Repeat with valid=0 → `seq_err_o` rises and stays high.
- `rst_n` pulsed low during LD_WAIT → IDLE immediately, all outputs 0 except `ready_o`=1, no `retire_o`.
